fifo_wr_feeder: RTL and testbench



---
 rtl/fifo_wr_feeder_if.sv | 32 +++
 rtl/fifo_wr_feeder.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_feeder.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_feeder_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_feeder_if
// Groups the upstream valid/ready stream and the async-FIFO write port used by
// fifo_wr_feeder into one bundle.
//   S_DATA/S_VALID/S_READY  : upstream word stream (S_READY returned by feeder)
//   FIFO_WR_DATA/FIFO_WR_EN : write port driven by the feeder
//   FIFO_WR_FULL/FIFO_WR_CNT: FIFO status returned to the feeder (CNT lags)
// modport slave  : the feeder side (consumes stream, drives FIFO write port)
// modport master : the environment side (produces stream, models the FIFO)
// ----------------------------------------------------------------------------
interface fifo_wr_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 11
);
    logic [DATA_WIDTH-1:0] S_DATA;
    logic                  S_VALID;
    logic                  S_READY;
    logic [DATA_WIDTH-1:0] FIFO_WR_DATA;
    logic                  FIFO_WR_EN;
    logic                  FIFO_WR_FULL;
    logic [CNT_WIDTH-1:0]  FIFO_WR_CNT;

    modport slave (
        input  S_DATA, S_VALID, FIFO_WR_FULL, FIFO_WR_CNT,
        output S_READY, FIFO_WR_DATA, FIFO_WR_EN
    );

    modport master (
        output S_DATA, S_VALID, FIFO_WR_FULL, FIFO_WR_CNT,
        input  S_READY, FIFO_WR_DATA, FIFO_WR_EN
    );
endinterface

// File: rtl/fifo_wr_feeder.sv
// ----------------------------------------------------------------------------
// fifo_wr_feeder
// Write-side front end for an async FIFO. Upstream words enter a 2-entry skid
// buffer and are forwarded to the FIFO write port one per cycle while the
// effective occupancy (lagging FIFO count plus writes it does not show yet)
// stays below FIFO_DEPTH-AFULL_MARGIN.
// Ports:
//   WR_CLK    : write-domain clock, rising edge
//   WR_RST_N  : asynchronous active-low reset
//   bus       : stream + FIFO write port bundle (slave modport)
//   WORD_CNT  : wrapping count of words accepted by the FIFO
//   OVF_ERR   : sticky, set when a write was issued while FIFO_WR_FULL=1
//   CLR_ERR   : clears OVF_ERR (a simultaneous new error wins)
// ----------------------------------------------------------------------------
module fifo_wr_feeder #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 1024,
    parameter int CNT_WIDTH    = 11,
    parameter int AFULL_MARGIN = 4,
    parameter int CNT_LAG      = 2
) (
    input  logic              WR_CLK,
    input  logic              WR_RST_N,
    fifo_wr_feeder_if.slave   bus,
    output logic [31:0]       WORD_CNT,
    output logic              OVF_ERR,
    input  logic              CLR_ERR
);

    // Wide enough for FIFO_WR_CNT plus up to five in-flight writes plus one.
    localparam int EW = CNT_WIDTH + 3;
    localparam logic [EW-1:0] LIMIT = EW'(FIFO_DEPTH - AFULL_MARGIN);

    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  s_ready_q, s_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CNT_LAG-1:0]    hist_q, hist_d;
    logic [31:0]           word_cnt_q, word_cnt_d;
    logic                  ovf_q, ovf_d;

    logic [EW-1:0]         inflight;
    logic [EW-1:0]         eff;
    logic                  space_ok;
    logic                  accept;
    logic                  drain;
    logic [1:0]            occ_left;

    // Writes issued but possibly not yet visible in FIFO_WR_CNT: the ones
    // still in the lag history plus the one on the port right now.
    always_comb begin
        inflight = EW'(wr_en_q);
        for (int i = 0; i < CNT_LAG; i++) begin
            inflight = inflight + EW'(hist_q[i]);
        end
        eff      = EW'(bus.FIFO_WR_CNT) + inflight;
        space_ok = !bus.FIFO_WR_FULL && ((eff + EW'(1)) <= LIMIT);
    end

    always_comb begin
        hist_d[0] = wr_en_q;
        for (int i = 1; i < CNT_LAG; i++) begin
            hist_d[i] = hist_q[i-1];
        end
    end

    // Skid buffer: pop the head first, then append the accepted word at
    // whatever slot is the tail after the pop, so order is preserved when
    // accept and drain coincide.
    always_comb begin
        accept    = bus.S_VALID && s_ready_q;
        drain     = (occ_q != 2'd0) && space_ok;
        head_d    = head_q;
        tail_d    = tail_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;

        if (drain) begin
            wr_en_d   = 1'b1;
            wr_data_d = head_q;
            if (occ_q == 2'd2) begin
                head_d = tail_q;
            end
        end

        occ_left = occ_q - {1'b0, drain};
        if (accept) begin
            if (occ_left == 2'd0) begin
                head_d = bus.S_DATA;
            end else begin
                tail_d = bus.S_DATA;
            end
        end

        occ_d     = occ_left + {1'b0, accept};
        s_ready_d = (occ_d != 2'd2);
    end

    // WORD_CNT counts only writes the FIFO actually took; a write into a full
    // FIFO raises the sticky error instead, and wins over a clear.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (wr_en_q && !bus.FIFO_WR_FULL) begin
            word_cnt_d = word_cnt_q + 32'd1;
        end

        ovf_d = ovf_q;
        if (wr_en_q && bus.FIFO_WR_FULL) begin
            ovf_d = 1'b1;
        end else if (CLR_ERR) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge WR_CLK or negedge WR_RST_N) begin
        if (!WR_RST_N) begin
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            s_ready_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            hist_q     <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            s_ready_q  <= s_ready_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            hist_q     <= hist_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.S_READY      = s_ready_q;
    assign bus.FIFO_WR_EN   = wr_en_q;
    assign bus.FIFO_WR_DATA = wr_data_q;
    assign WORD_CNT         = word_cnt_q;
    assign OVF_ERR          = ovf_q;

endmodule

// File: tb/tb_fifo_wr_feeder.sv
module tb_fifo_wr_feeder;
    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int CW     = 5;
    localparam int MARGIN = 4;
    localparam int LAG    = 2;
    localparam int THRESH = DEPTH - MARGIN;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr_err = 1'b0;
    logic [31:0] word_cnt;
    logic        ovf_err;

    fifo_wr_feeder_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_wr_feeder #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW),
        .AFULL_MARGIN(MARGIN), .CNT_LAG(LAG)
    ) dut (
        .WR_CLK(clk),
        .WR_RST_N(rst_n),
        .bus(bus),
        .WORD_CNT(word_cnt),
        .OVF_ERR(ovf_err),
        .CLR_ERR(clr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state
    logic [31:0] sb[$];
    int          acc_cyc[$];
    int          wr_cyc[$];
    int          exp_wc = 0;
    bit          exp_ovf = 1'b0;
    int          n_wr = 0;
    bit          mon_en = 1'b0;
    int          cyc = 0;

    // FIFO model: true occupancy, count visible with a lag of LAG edges
    int          true_occ = 0;
    int          cnt_p1 = 0;
    int          cnt_p2 = 0;
    int          rd_mode = 0;   // 0 none, 1 random, 2 every cycle
    bit          force_full = 1'b0;
    bit          flush = 1'b0;
    bit          drv_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    assign bus.FIFO_WR_FULL = force_full || (true_occ >= DEPTH);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        int n;
        n = true_occ;
        if (bus.FIFO_WR_EN === 1'b1 && !bus.FIFO_WR_FULL) n = n + 1;
        if (true_occ > 0 && (rd_mode == 2 || (rd_mode == 1 && $urandom_range(0, 1) == 1))) n = n - 1;
        if (flush) begin
            true_occ <= 0;
            cnt_p1   <= 0;
            cnt_p2   <= 0;
            bus.FIFO_WR_CNT <= '0;
        end else begin
            true_occ <= n;
            cnt_p1   <= n;
            cnt_p2   <= cnt_p1;
            bus.FIFO_WR_CNT <= CW'(cnt_p2);
        end
    end

    // Monitor: compares registered outputs against the reference state, pops
    // the scoreboard on every write, pushes on every handshake.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("word_cnt", word_cnt, 32'(exp_wc));
            chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
            if (bus.FIFO_WR_EN) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got 0x%0h expected none", bus.FIFO_WR_DATA);
                end else begin
                    chk("wr_data", bus.FIFO_WR_DATA, sb.pop_front());
                end
                if (!force_full) chk("afull_limit", 32'(true_occ < THRESH), 32'd1);
                n_wr++;
                wr_cyc.push_back(cyc);
                if (!bus.FIFO_WR_FULL) exp_wc++;
            end
            if (bus.FIFO_WR_EN && bus.FIFO_WR_FULL) exp_ovf = 1'b1;
            else if (clr_err) exp_ovf = 1'b0;
            if (bus.S_VALID && bus.S_READY) begin
                sb.push_back(bus.S_DATA);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [31:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        bus.S_DATA  = d;
        bus.S_VALID = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (bus.S_READY && rst_n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("send_timeout");
        @(posedge clk);
        #1;
        bus.S_VALID = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_wc     = 0;
        exp_ovf    = 1'b0;
        force_full = 1'b0;
        clr_err    = 1'b0;
        #1;
        chk("rst_s_ready", 32'(bus.S_READY), 32'd0);
        chk("rst_wr_en", 32'(bus.FIFO_WR_EN), 32'd0);
        chk("rst_wr_data", bus.FIFO_WR_DATA, 32'd0);
        chk("rst_word_cnt", word_cnt, 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.S_READY), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.FIFO_WR_EN) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drv(input int bound);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            @(posedge clk);
            if (drv_done) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) fail("driver_timeout");
    endtask

    task automatic do_flush();
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_wr_en(input string nm);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (bus.FIFO_WR_EN) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail(nm);
    endtask

    initial begin
        int base;
        bus.S_DATA  = '0;
        bus.S_VALID = 1'b0;

        // Reset state
        do_reset();

        // Stream 1..8, sink always reading
        rd_mode = 2;
        acc_cyc.delete();
        wr_cyc.delete();
        for (int i = 1; i <= 8; i++) send(32'(i), 0);
        wait_idle();
        chk("t1_nwrites", 32'(wr_cyc.size()), 32'd8);
        if (acc_cyc.size() > 0 && wr_cyc.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t1_wr_cycle", 32'(wr_cyc[i]), 32'(acc_cyc[0] + 2 + i));
        end else begin
            fail("t1_latency_logs");
        end
        chk("t1_word_cnt", word_cnt, 32'd8);

        // Threshold: no reads, continuous valid
        do_flush();
        rd_mode  = 0;
        base     = n_wr;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), 0);
                drv_done = 1'b1;
            end
        join_none
        repeat (40) @(posedge clk);
        #1;
        chk("t2_writes", 32'(n_wr - base), 32'(THRESH));
        chk("t2_true_occ", 32'(true_occ), 32'(THRESH));
        chk("t2_s_ready", 32'(bus.S_READY), 32'd0);
        chk("t2_ovf", 32'(ovf_err), 32'd0);
        rd_mode = 2;
        wait_drv(2000);
        wait_idle();
        chk("t2_total", 32'(n_wr - base), 32'd16);

        // FIFO full held for 10 cycles with 2 words buffered
        do_flush();
        rd_mode  = 0;
        base     = n_wr;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(32'h200 + 32'(i), 0);
                drv_done = 1'b1;
            end
        join_none
        repeat (40) @(posedge clk);
        #1;
        force_full = 1'b1;
        rd_mode    = 2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_wr_en_held", 32'(bus.FIFO_WR_EN), 32'd0);
        end
        @(posedge clk);
        #1;
        force_full = 1'b0;
        wait_drv(2000);
        wait_idle();
        chk("t3_total", 32'(n_wr - base), 32'd20);
        chk("t3_ovf", 32'(ovf_err), 32'd0);

        // Overflow error: set, clear, clear colliding with a new error
        rd_mode = 2;
        send(32'h55, 0);
        wait_wr_en("t5_wr_en_1");
        force_full = 1'b1;
        @(posedge clk);
        #1;
        force_full = 1'b0;
        @(negedge clk);
        chk("t5_ovf_set", 32'(ovf_err), 32'd1);
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(negedge clk);
        chk("t5_ovf_clr", 32'(ovf_err), 32'd0);
        @(posedge clk);
        #1;
        send(32'h56, 0);
        wait_wr_en("t5_wr_en_2");
        force_full = 1'b1;
        clr_err    = 1'b1;
        @(posedge clk);
        #1;
        force_full = 1'b0;
        clr_err    = 1'b0;
        @(negedge clk);
        chk("t5_set_wins", 32'(ovf_err), 32'd1);
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        wait_idle();

        // Async reset with two words buffered, then fresh words
        force_full = 1'b1;
        rd_mode    = 0;
        send(32'h71, 0);
        send(32'h72, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_ready_full", 32'(bus.S_READY), 32'd0);
        do_reset();
        rd_mode = 2;
        send(32'hA, 0);
        send(32'hB, 0);
        wait_idle();

        // Async reset mid-stream drops outputs immediately
        rd_mode  = 2;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'h61 + 32'(i), 0);
                drv_done = 1'b1;
            end
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("t7_ready_pre", 32'(bus.S_READY), 32'd1);
        chk("t7_wr_en_pre", 32'(bus.FIFO_WR_EN), 32'd1);
        do_reset();
        wait_drv(2000);
        wait_idle();

        // Random valid gaps and random FIFO drain, 10k words
        do_reset();
        rd_mode  = 1;
        base     = n_wr;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) send($urandom, $urandom_range(0, 2));
                drv_done = 1'b1;
            end
        join_none
        wait_drv(80000);
        wait_idle();
        chk("t4_writes", 32'(n_wr - base), 32'd10000);
        chk("t4_word_cnt", word_cnt, 32'd10000);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
